// File: rtl/serie_paralelo_rx.sv
// Receive-side serial-to-parallel converter: hunts for the comma, confirms byte
// alignment on BC_COUNT consecutive commas, then rebuilds MSB-first bytes.
module serie_paralelo_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

  state_t     state_r;
  logic [6:0] sr_r;
  logic [2:0] bit_cnt_r;
  logic [3:0] comma_cnt_r;
  logic [7:0] asm_s;
  logic       is_comma_s;
  logic       boundary_s;

  // Only the 7 most recent bits are stored; the current bit completes the byte.
  assign asm_s      = {sr_r, data_in};
  assign is_comma_s = (asm_s == COMMA);
  assign boundary_s = (bit_cnt_r == 3'd7);

  // Shift register, alignment FSM and registered byte outputs.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_r     <= SEARCH;
      sr_r        <= 7'd0;
      bit_cnt_r   <= 3'd0;
      comma_cnt_r <= 4'd0;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      sr_r        <= asm_s[6:0];
      byte_strobe <= 1'b0;
      case (state_r)
        SEARCH: begin
          // Bit-sliding hunt: the edge that completes a comma becomes a boundary.
          bit_cnt_r <= 3'd0;
          if (is_comma_s) begin
            comma_cnt_r <= 4'd1;
            if (BC_LIM == 4'd1) begin
              state_r <= ACTIVE;
              active  <= 1'b1;
            end else begin
              state_r <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (boundary_s) begin
            if (is_comma_s) begin
              if (comma_cnt_r + 4'd1 >= BC_LIM) begin
                comma_cnt_r <= BC_LIM;
                state_r     <= ACTIVE;
                active      <= 1'b1;
              end else begin
                comma_cnt_r <= comma_cnt_r + 4'd1;
              end
            end else begin
              comma_cnt_r <= 4'd0;
              state_r     <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (boundary_s) begin
            byte_strobe <= 1'b1;
            if (!is_comma_s) begin
              data_out  <= asm_s;
              valid_out <= 1'b1;
            end else begin
              valid_out <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx: two instances (BC_COUNT=4 and BC_COUNT=1) share one
// stimulus stream and are checked every cycle against an edge-index based model.
module tb_serie_paralelo_rx;

  logic clk_8f  = 1'b0;
  logic reset   = 1'b1;
  logic data_in = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  initial forever #5 clk_8f = ~clk_8f;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int BC = (g == 0) ? 4 : 1;
    logic [7:0] dout;
    logic       vout, act, strobe;

    serie_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(BC)) dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (dout),
      .valid_out   (vout),
      .active      (act),
      .byte_strobe (strobe)
    );

    // Model: remember the edge index where the lock happened; boundaries are
    // every 8th edge after it.
    logic [7:0] m_hist;
    int         m_e, m_anchor, m_commas;
    logic       m_locked, m_act, m_vout, m_strobe;
    logic [7:0] m_dout;
    wire  [7:0] m_w = {m_hist[6:0], data_in};

    always @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
        m_hist <= 8'd0; m_e <= 0; m_anchor <= 0; m_commas <= 0;
        m_locked <= 1'b0; m_act <= 1'b0; m_vout <= 1'b0; m_strobe <= 1'b0;
        m_dout <= 8'd0;
      end else begin
        m_hist   <= m_w;
        m_e      <= m_e + 1;
        m_strobe <= 1'b0;
        if (!m_locked) begin
          if (m_w == 8'hBC) begin
            m_locked <= 1'b1;
            m_anchor <= m_e;
            m_commas <= 1;
            if (BC == 1) m_act <= 1'b1;
          end
        end else if ((m_e - m_anchor) % 8 == 0) begin
          if (m_act) begin
            m_strobe <= 1'b1;
            if (m_w != 8'hBC) begin
              m_dout <= m_w;
              m_vout <= 1'b1;
            end else begin
              m_vout <= 1'b0;
            end
          end else if (m_w == 8'hBC) begin
            m_commas <= m_commas + 1;
            if (m_commas + 1 == BC) m_act <= 1'b1;
          end else begin
            m_locked <= 1'b0;
            m_commas <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk_8f);
    chk("dout0",   u[0].dout,   u[0].m_dout);
    chk("vout0",   u[0].vout,   u[0].m_vout);
    chk("act0",    u[0].act,    u[0].m_act);
    chk("strobe0", u[0].strobe, u[0].m_strobe);
    chk("dout1",   u[1].dout,   u[1].m_dout);
    chk("vout1",   u[1].vout,   u[1].m_vout);
    chk("act1",    u[1].act,    u[1].m_act);
    chk("strobe1", u[1].strobe, u[1].m_strobe);
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    data_in = 1'b0;
    @(posedge clk_8f);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk_8f);
    #1;
    chk("rst_dout", u[0].dout, 8'h00);
    chk("rst_vout", u[0].vout, 8'h00);
    chk("rst_act",  u[0].act,  8'h00);
    chk("rst_strb", u[0].strobe, 8'h00);
    reset = 1'b1;

    // Idle commas from edge 0: active at edge 31, first strobe at edge 39.
    repeat (3) send_byte(8'hBC);
    chk("idle_act_early", u[0].act, 8'h00);
    send_byte(8'hBC);
    chk("idle_act31", u[0].act, 8'h01);
    chk("idle_strb31", u[0].strobe, 8'h00);
    send_byte(8'hBC);
    chk("idle_strb39", u[0].strobe, 8'h01);
    chk("idle_vout39", u[0].vout, 8'h00);

    // Data/idle interleave while active.
    send_byte(8'h01);
    chk("il_d0", u[0].dout, 8'h01); chk("il_v0", u[0].vout, 8'h01); chk("il_s0", u[0].strobe, 8'h01);
    send_byte(8'hBC);
    chk("il_d1", u[0].dout, 8'h01); chk("il_v1", u[0].vout, 8'h00); chk("il_s1", u[0].strobe, 8'h01);
    send_byte(8'hFF);
    chk("il_d2", u[0].dout, 8'hFF); chk("il_v2", u[0].vout, 8'h01);
    send_byte(8'h00);
    chk("il_d3", u[0].dout, 8'h00); chk("il_v3", u[0].vout, 8'h01);

    // Async reset in the middle of 0x5A.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_dout", u[0].dout, 8'h00);
    chk("ar_vout", u[0].vout, 8'h00);
    chk("ar_act",  u[0].act,  8'h00);
    chk("ar_act1", u[1].act,  8'h00);
    @(posedge clk_8f);
    #1;
    reset = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk("ar_act_3c", u[0].act, 8'h00);
    send_byte(8'hBC);
    chk("ar_act_4c", u[0].act, 8'h01);

    // Misaligned lock: three leading bits shift the comma phase.
    pulse_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (4) send_byte(8'hBC);
    chk("mis_act", u[0].act, 8'h01);
    send_byte(8'hBC);
    send_byte(8'hA5);
    chk("mis_dout", u[0].dout, 8'hA5); chk("mis_vout", u[0].vout, 8'h01); chk("mis_strb", u[0].strobe, 8'h01);
    send_bit(1'b0);
    chk("mis_hold", u[0].dout, 8'hA5); chk("mis_strb_off", u[0].strobe, 8'h00);

    // Broken alignment: 0x3C drops back to the hunt.
    pulse_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h3C);
    chk("brk_act_3c", u[0].act, 8'h00);
    repeat (3) send_byte(8'hBC);
    chk("brk_act_3", u[0].act, 8'h00);
    send_byte(8'hBC);
    chk("brk_act_4", u[0].act, 8'h01);

    // BC_COUNT=1 instance: active at the first comma.
    pulse_reset();
    send_byte(8'hBC);
    chk("p1_act", u[1].act, 8'h01);
    chk("p4_act", u[0].act, 8'h00);
    send_byte(8'h7E);
    chk("p1_dout", u[1].dout, 8'h7E); chk("p1_vout", u[1].vout, 8'h01); chk("p1_strb", u[1].strobe, 8'h01);

    repeat (2) @(posedge clk_8f);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
